// File: rtl/bsmodmul_ctrl.sv
// bsmodmul_ctrl: sequencer for the bit-serial modular multiplier.
// Takes a parallel operand pair, streams operand a LSB first into the
// multiplier with a single isync strobe, and deserializes the osync-framed
// serial result into a parallel response word.
//
// Optional build macro: BSMODMUL_CTRL_TIMEOUT_EN
//   defined   -> capture must start within TIMEOUT cycles of isync, otherwise
//                the operation ends with rsp_err=1 and rsp_q=0.
//   undefined -> no watchdog; RUN waits for osync indefinitely, rsp_err=0.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a request; mm_b keeps the last latched operand
// RUN   | send a (FRAME bit-cycles) and capture q (LEN bits) concurrently
// DONE  | response valid and held until rsp_ready

module bsmodmul_ctrl #(
  parameter int LEN     = 94,
  parameter int FRAME   = 2*LEN,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [LEN-1:0] req_a,
  input  logic [LEN-1:0] req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [LEN-1:0] rsp_q,
  output logic           rsp_err,
  output logic           mm_a,
  output logic [LEN-1:0] mm_b,
  output logic           mm_isync,
  input  logic           mm_q,
  input  logic           mm_osync
);

  localparam int SW = $clog2(FRAME + 1);
  localparam int CW = $clog2(LEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [SW-1:0] SCNT_LAST = SW'(FRAME - 1);
  localparam logic [SW-1:0] SCNT_LEN  = SW'(LEN);
  localparam logic [CW-1:0] CCNT_LAST = CW'(LEN - 1);
  localparam logic [CW-1:0] CCNT_FULL = CW'(LEN);

  logic [1:0]     r_state;
  logic [SW-1:0]  r_scnt;
  logic           r_send_done;
  logic [LEN-1:0] r_sh;
  logic [LEN-1:0] r_b;
  logic [LEN-1:0] r_q;
  logic           r_cap_on;
  logic [CW-1:0]  r_ccnt;

  logic w_run;
  logic w_accept;
  logic w_sending;
  logic w_send_fin;
  logic w_cap_done;
  logic w_cap_take;
  logic w_cap_fin;
  logic w_tmo_exp;
  logic w_tmo_fin;
  logic w_to_done;

  assign w_run      = (r_state == S_RUN);
  assign w_accept   = (r_state == S_IDLE) && req_valid;
  assign w_sending  = w_run && !r_send_done;
  // send finishes in the cycle that drives the last frame bit
  assign w_send_fin = r_send_done || (w_sending && (r_scnt == SCNT_LAST));

  // capture: first osync starts it, later osync pulses are don't-care
  assign w_cap_done = r_cap_on && (r_ccnt == CCNT_FULL);
  assign w_cap_take = w_run && !w_cap_done && (r_cap_on || (mm_osync && !w_tmo_exp));
  assign w_cap_fin  = w_cap_done || (w_cap_take && (r_ccnt == CCNT_LAST));

`ifdef BSMODMUL_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo;
  logic          r_err;

  // an expired watchdog also blocks a late capture start
  assign w_tmo_exp = (r_tmo == '0);
  assign w_tmo_fin = w_run && !r_cap_on && w_tmo_exp;

  // watchdog: down-counter loaded at acceptance, runs from the isync cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo <= '0;
    end else if (w_accept) begin
      r_tmo <= TW'(TIMEOUT);
    end else if (w_run && !r_cap_on && !w_tmo_exp) begin
      r_tmo <= r_tmo - TW'(1);
    end
  end

  // error flag: set when RUN ends without a completed capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_to_done) begin
      r_err <= !w_cap_fin;
    end
  end

  assign rsp_err = r_err;
`else
  logic w_unused_tmo;

  assign w_tmo_exp    = 1'b0;
  assign w_tmo_fin    = 1'b0;
  assign rsp_err      = 1'b0;
  assign w_unused_tmo = (TIMEOUT > 0);
`endif

  assign w_to_done = w_run && w_send_fin && (w_cap_fin || w_tmo_fin);

  // main sequencing FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept)  r_state <= S_RUN;
        S_RUN:   if (w_to_done) r_state <= S_DONE;
        S_DONE:  if (rsp_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // send path: operand latch, serial shift of a, frame counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sh        <= '0;
      r_b         <= '0;
      r_scnt      <= '0;
      r_send_done <= 1'b0;
    end else if (w_accept) begin
      r_sh        <= req_a;
      r_b         <= req_b;
      r_scnt      <= '0;
      r_send_done <= 1'b0;
    end else if (w_sending) begin
      r_sh <= {1'b0, r_sh[LEN-1:1]};
      if (r_scnt == SCNT_LAST) begin
        r_send_done <= 1'b1;
      end else begin
        r_scnt <= r_scnt + SW'(1);
      end
    end
  end

  // capture path: shift q in from the top so the first bit lands in bit 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q      <= '0;
      r_cap_on <= 1'b0;
      r_ccnt   <= '0;
    end else if (w_accept) begin
      r_q      <= '0;
      r_cap_on <= 1'b0;
      r_ccnt   <= '0;
    end else if (w_cap_take) begin
      r_q      <= {mm_q, r_q[LEN-1:1]};
      r_cap_on <= 1'b1;
      r_ccnt   <= r_ccnt + CW'(1);
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_DONE);
  assign rsp_q     = r_q;
  assign mm_b      = r_b;
  // padding bits after the LEN data bits are driven as zero
  assign mm_a      = w_sending && (r_scnt < SCNT_LEN) && r_sh[0];
  assign mm_isync  = w_sending && (r_scnt == '0);

endmodule

// File: tb/tb_bsmodmul_ctrl.sv
// tb_bsmodmul_ctrl: directed bench for bsmodmul_ctrl with a behavioural
// multiplier stub (real modmul with fixed latency, fixed pattern, or silent).
module tb_bsmodmul_ctrl;

  localparam int LEN     = 94;
  localparam int FRAME   = 2*LEN;
  localparam int TIMEOUT = 300;
  localparam int OS_REAL = LEN + 4;
  localparam int OS_PAT  = 5;

  logic           clk;
  logic           reset;
  logic           req_valid;
  logic           req_ready;
  logic [LEN-1:0] req_a;
  logic [LEN-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [LEN-1:0] rsp_q;
  logic           rsp_err;
  logic           mm_a;
  logic [LEN-1:0] mm_b;
  logic           mm_isync;
  logic           mm_q;
  logic           mm_osync;

  logic stub_q, stub_os, man_q, man_os;
  assign mm_q     = stub_q | man_q;
  assign mm_osync = stub_os | man_os;

  int n_tot = 0;
  int n_bad = 0;

  bsmodmul_ctrl #(.LEN(LEN), .FRAME(FRAME), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_q(rsp_q), .rsp_err(rsp_err),
    .mm_a(mm_a), .mm_b(mm_b), .mm_isync(mm_isync),
    .mm_q(mm_q), .mm_osync(mm_osync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stub state: 0 = silent, 1 = real modmul, 2 = fixed pattern
  int             stub_mode = 0;
  int             k = -1;
  logic [LEN-1:0] p_mod;
  logic [LEN-1:0] a_acc;
  logic [LEN-1:0] res;
  logic [191:0]   wa, wb, wp, wr;
  logic [95:0]    pat96 = 96'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5;

  always @(negedge clk) begin
    stub_os = 1'b0;
    stub_q  = 1'b0;
    if (!reset) begin
      k = -1;
    end else begin
      if (mm_isync) begin
        k = 0;
        a_acc = '0;
      end else if (k >= 0) begin
        k = k + 1;
      end
      if (k >= 0 && k < LEN) a_acc[k] = mm_a;
      if (k == LEN) begin
        wa  = {98'd0, a_acc};
        wb  = {98'd0, mm_b};
        wp  = {98'd0, p_mod};
        wr  = (wa * wb) % wp;
        res = wr[LEN-1:0];
      end
      if (stub_mode == 1 && k >= OS_REAL && k < OS_REAL + LEN) begin
        stub_os = (k == OS_REAL);
        stub_q  = res[k - OS_REAL];
      end
      if (stub_mode == 2) begin
        if (k == OS_PAT || k == OS_PAT + 10) stub_os = 1'b1;
        if (k >= OS_PAT && k < OS_PAT + LEN) stub_q = pat96[k - OS_PAT];
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // entered #1 after acceptance edge T, i.e. in cycle T+1
  task automatic wait_rsp(input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                          output logic [LEN-1:0] q, output logic e, output int lat);
    int   n_is;
    int   a_bad;
    logic ea;
    n_is  = 0;
    a_bad = 0;
    lat   = -1;
    chk("isync_T1", mm_isync, 1);
    chk("mm_b_latched", mm_b, b);
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      if (rsp_valid === 1'b1) begin
        lat = cyc;
        break;
      end
      if (mm_isync) n_is++;
      ea = (cyc <= LEN) ? a[cyc-1] : 1'b0;
      if (mm_a !== ea) a_bad++;
      @(posedge clk); #1;
    end
    chk("rsp_in_budget", lat > 0, 1);
    chk("isync_once", n_is, 1);
    chk("mm_a_serial", a_bad, 0);
    q = rsp_q;
    e = rsp_err;
  endtask

  task automatic run_op(input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                        output logic [LEN-1:0] q, output logic e, output int lat);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(a, b, q, e, lat);
  endtask

  task automatic take_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
    chk("ready_back", req_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LEN-1:0] q, sq, a, pm1;
    logic           e;
    int             lat;
    int             bad;

    p_mod = '1;
    p_mod = p_mod - LEN'(2);
    pm1   = p_mod - LEN'(1);
    reset = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    man_q = 1'b0; man_os = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_q", rsp_q, 0);
    chk("rst_mm_a", mm_a, 0);
    chk("rst_mm_b", mm_b, 0);
    chk("rst_mm_isync", mm_isync, 0);
    @(negedge clk);
    reset = 1'b1;

    // real datapath: results and latency S+LEN = T+1+OS_REAL+LEN
    stub_mode = 1;
    run_op(LEN'(3), LEN'(5), q, e, lat);
    chk("mul_3x5", q, 15);
    chk("mul_3x5_err", e, 0);
    chk("mul_3x5_lat", lat, 1 + OS_REAL + LEN);
    take_rsp();

    a = '0;
    a[LEN-1] = 1'b1;
    run_op(a, LEN'(2), q, e, lat);
    chk("mul_2p93x2", q, 3);
    take_rsp();

    run_op(pm1, pm1, q, e, lat);
    chk("mul_pm1_sq", q, 1);
    take_rsp();

    // early osync: capture done well before send, valid waits for T+FRAME+1
    stub_mode = 2;
    run_op(LEN'(94'h1234_5678), LEN'(7), q, e, lat);
    chk("pat_capture", q, pat96[LEN-1:0]);
    chk("pat_err", e, 0);
    chk("pat_lat", lat, FRAME + 1);

    // backpressure with a pending request, then accept at R+1
    sq = q;
    @(negedge clk);
    req_valid = 1'b1; req_a = LEN'(3); req_b = LEN'(5);
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_q !== sq || mm_b !== LEN'(7)) bad++;
    end
    chk("hold_stable", bad, 0);
    stub_mode = 1;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("R1_rsp_valid", rsp_valid, 0);
    chk("R1_req_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(LEN'(3), LEN'(5), q, e, lat);
    chk("b2b_3x5", q, 15);
    take_rsp();

    // datapath never answers
    stub_mode = 0;
`ifdef BSMODMUL_CTRL_TIMEOUT_EN
    run_op(LEN'(9), LEN'(9), q, e, lat);
    chk("tmo_err", e, 1);
    chk("tmo_q", q, 0);
    take_rsp();
`else
    @(negedge clk);
    req_valid = 1'b1; req_a = LEN'(9); req_b = LEN'(9);
    @(posedge clk); #1;
    req_valid = 1'b0;
    bad = 0;
    repeat (5000) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0) bad++;
    end
    chk("no_tmo_stays_run", bad, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
`endif

    // reset mid-capture (ccnt=40 in cycle T+1+OS_REAL+40)
    stub_mode = 1;
    @(negedge clk);
    req_valid = 1'b1; req_a = LEN'(7); req_b = LEN'(9);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (OS_REAL + 40) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    bad = 0;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_q !== '0 || mm_a !== 1'b0 ||
        mm_b !== '0 || mm_isync !== 1'b0) bad++;
    chk("midop_rst_outputs", bad, 0);
    chk("midop_rst_ready", req_ready, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    man_os = 1'b1; man_q = 1'b1;
    @(negedge clk);
    man_os = 1'b0; man_q = 1'b0;
    bad = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mm_isync !== 1'b0) bad++;
    end
    chk("late_osync_ignored", bad, 0);
    run_op(LEN'(3), LEN'(5), q, e, lat);
    chk("post_rst_3x5", q, 15);
    take_rsp();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
